// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: owns the single register-file write port and shares it
// between the core writeback path (requester 0) and a secondary path
// (requester 1). Out of reset it first sweeps zeros into every register,
// because the register array itself has no reset, and only then grants.
// Optional macro RF_STARVE_GUARD_EN: promotes requester 1 after STARVE_LIMIT
// consecutive stalled cycles; without it requester 0 has strict priority.
module rf_wr_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32,
   parameter int NUM_REGS     = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              init_done,
   output logic              x0_drop
);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

   // The sweep pointer wraps exactly onto the register range, so the
   // register count must be a power of two matching the address width.
   if (NUM_REGS != (1 << ADDR_W) || STARVE_LIMIT < 1) begin : g_cfg_check
      $error("rf_wr_arbiter: NUM_REGS must equal 2**ADDR_W and STARVE_LIMIT must be >= 1");
   end

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic              init_done_q, init_done_d;
   logic              x0_drop_q, x0_drop_d;

   logic              run;
   logic              xfer0, xfer1;
   logic              xfer;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // Async reset forces INIT, so both readies are low during reset.
   assign run = (state_q == ST_RUN);

`ifdef RF_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             promote;

   assign promote = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

   // Grant: requester 0 first, unless requester 1 has waited long enough.
   always_comb begin
      req0_ready = run && !promote;
      req1_ready = run && (promote || !req0_valid);
   end

   // Count consecutive stalled cycles of a pending requester 1 write.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (run) begin
         if (!req1_valid || xfer1) begin
            starve_cnt_d = '0;
         end else if (!promote) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   // Grant: strict fixed priority for requester 0.
   always_comb begin
      req0_ready = run;
      req1_ready = run && !req0_valid;
   end
`endif

   assign xfer0 = req0_valid && req0_ready;
   assign xfer1 = req1_valid && req1_ready;
   assign xfer  = xfer0 || xfer1;

   // Select the winning request; the grant logic never accepts both.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      win_addr = req1_addr;
      win_data = req1_data;
      if (xfer0) begin
         win_addr = req0_addr;
         win_data = req0_data;
      end
   end

   // Next-state: clear sweep in INIT, one-cycle-latency writeback in RUN.
   always_comb begin
      state_d     = state_q;
      init_ptr_d  = init_ptr_q;
      rf_we_d     = 1'b0;
      rf_addr_d   = rf_addr_q;
      rf_wdata_d  = rf_wdata_q;
      init_done_d = init_done_q;
      x0_drop_d   = 1'b0;
      case (state_q)
         ST_INIT: begin
            rf_we_d    = 1'b1;
            rf_addr_d  = init_ptr_q;
            rf_wdata_d = '0;
            init_ptr_d = init_ptr_q + ADDR_W'(1);
            if (init_ptr_q == LAST_PTR) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (xfer) begin
               // x0 is hardwired zero: acknowledge, suppress, flag it.
               if (win_addr == '0) begin
                  x0_drop_d = 1'b1;
               end else begin
                  rf_we_d    = 1'b1;
                  rf_addr_d  = win_addr;
                  rf_wdata_d = win_data;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State and registered write-port outputs.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= ST_INIT;
         init_ptr_q  <= '0;
         rf_we_q     <= 1'b0;
         rf_addr_q   <= '0;
         rf_wdata_q  <= '0;
         init_done_q <= 1'b0;
         x0_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_ptr_q  <= init_ptr_d;
         rf_we_q     <= rf_we_d;
         rf_addr_q   <= rf_addr_d;
         rf_wdata_q  <= rf_wdata_d;
         init_done_q <= init_done_d;
         x0_drop_q   <= x0_drop_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_addr   = rf_addr_q;
   assign rf_wdata  = rf_wdata_q;
   assign init_done = init_done_q;
   assign x0_drop   = x0_drop_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed stimulus with a reference model that pushes
// the expected write-port outputs into a scoreboard queue as each cycle is
// driven, and pops/compares them one cycle later.
module tb_rf_wr_arbiter;

   localparam int ADDR_W       = 5;
   localparam int DATA_W       = 32;
   localparam int NUM_REGS     = 32;
   localparam int STARVE_LIMIT = 4;
`ifdef RF_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              x0;
      logic              done;
      logic              chk_ad;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req1_valid;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic [DATA_W-1:0] req0_data, req1_data;
   logic              req0_ready, req1_ready;
   logic              rf_we, init_done, x0_drop;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_wdata;

   int n_cmp  = 0;
   int n_fail = 0;

   exp_t sb[$];

   // Reference model state.
   bit                m_run;
   int                m_sweep;
   int                m_starve;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   bit                m_known;
   bit                g0, g1;
   int                n_grant1;

   rf_wr_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
      .init_done(init_done), .x0_drop(x0_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run    = 1'b0;
      m_sweep  = 0;
      m_starve = 0;
      m_addr   = '0;
      m_data   = '0;
      m_known  = 1'b1;
      sb.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " rf_we"}, 64'(rf_we), 64'd0);
      check({tag, " rf_addr"}, 64'(rf_addr), 64'd0);
      check({tag, " rf_wdata"}, 64'(rf_wdata), 64'd0);
      check({tag, " init_done"}, 64'(init_done), 64'd0);
      check({tag, " x0_drop"}, 64'(x0_drop), 64'd0);
      check({tag, " req0_ready"}, 64'(req0_ready), 64'd0);
      check({tag, " req1_ready"}, 64'(req1_ready), 64'd0);
   endtask

   // One clock: settle inputs, predict and check readies, push the expected
   // next-cycle write-port state, clock, then pop and compare.
   task automatic cycle();
      exp_t              e;
      bit                er0, er1, t0, t1, promote;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      #1;
      t0 = 1'b0;
      t1 = 1'b0;
      if (!m_run) begin
         er0      = 1'b0;
         er1      = 1'b0;
         e.we     = 1'b1;
         e.addr   = ADDR_W'(m_sweep);
         e.data   = '0;
         e.x0     = 1'b0;
         e.chk_ad = 1'b1;
         m_addr   = ADDR_W'(m_sweep);
         m_data   = '0;
         m_known  = 1'b1;
         m_sweep++;
         if (m_sweep == NUM_REGS) m_run = 1'b1;
         e.done   = m_run;
      end else begin
         promote = GUARD && (m_starve == STARVE_LIMIT);
         er0     = !promote;
         er1     = promote || !req0_valid;
         t0      = req0_valid && er0;
         t1      = req1_valid && er1;
         e.done  = 1'b1;
         e.we    = 1'b0;
         e.x0    = 1'b0;
         if (t0 || t1) begin
            a = t0 ? req0_addr : req1_addr;
            d = t0 ? req0_data : req1_data;
            if (a == '0) begin
               e.x0    = 1'b1;
               m_known = 1'b0;
            end else begin
               e.we    = 1'b1;
               m_addr  = a;
               m_data  = d;
               m_known = 1'b1;
            end
         end
         e.addr   = m_addr;
         e.data   = m_data;
         e.chk_ad = m_known;
         if (GUARD) begin
            if (!req1_valid || t1) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
         end
      end
      g0 = t0;
      g1 = t1;
      if (t1) n_grant1++;
      check("req0_ready", 64'(req0_ready), 64'(er0));
      check("req1_ready", 64'(req1_ready), 64'(er1));
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         check("rf_we", 64'(rf_we), 64'(e.we));
         check("x0_drop", 64'(x0_drop), 64'(e.x0));
         check("init_done", 64'(init_done), 64'(e.done));
         if (e.we || e.chk_ad) begin
            check("rf_addr", 64'(rf_addr), 64'(e.addr));
            check("rf_wdata", 64'(rf_wdata), 64'(e.data));
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_addr  = '0;
      req1_addr  = '0;
      req0_data  = '0;
      req1_data  = '0;
      n_grant1   = 0;
      model_reset();

      // Reset state, then sweep with both requesters already pending.
      #12;
      check_reset_outputs("reset");
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1234_5678;
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h8765_4321;
      rst = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) cycle();
      check("no_grant_during_sweep", 64'(n_grant1), 64'd0);

      // Idle RUN cycle: rf_we drops, address/data hold at the last sweep write.
      req0_valid = 1'b0; req1_valid = 1'b0;
      cycle();

      // Single requester-0 write.
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
      cycle();
      check("req0_single_grant", 64'(g0), 64'd1);
      req0_valid = 1'b0;

      // Same destination from both: requester 0 wins, requester 1 retries.
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
      req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h22;
      cycle();
      check("collide_r0_first", 64'(g0), 64'd1);
      req0_valid = 1'b0;
      cycle();
      check("collide_r1_second", 64'(g1), 64'd1);
      req1_valid = 1'b0;
      cycle();

      // Write to x0 from requester 1: acknowledged, suppressed, one-cycle flag.
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
      cycle();
      check("x0_ack", 64'(g1), 64'd1);
      req1_valid = 1'b0;
      cycle();

      // Back-to-back requester-0 writes, one per cycle.
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1'b1; req0_addr = ADDR_W'(20 + i); req0_data = 32'hA000_0000 + 32'(i);
         cycle();
      end
      req0_valid = 1'b0;
      cycle();

      // Both valid continuously: requester 1 wins only with the guard enabled.
      n_grant1 = 0;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB000_0000;
      for (int i = 0; i < 10; i++) begin
         req0_valid = 1'b1; req0_addr = ADDR_W'(10 + i); req0_data = 32'hC000_0000 + 32'(i);
         cycle();
         if (g1) req1_data = req1_data + 32'd1;
      end
      check("starve_r1_grants", 64'(n_grant1), GUARD ? 64'd2 : 64'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      cycle();

      // Reset mid-sweep at index 10: asynchronous clear, sweep restarts at 0.
      rst = 1'b1; #3; rst = 1'b0;
      model_reset();
      req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h5555_5555;
      for (int i = 0; i < 10; i++) cycle();
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("mid_sweep_reset");
      model_reset();
      #1 rst = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) cycle();
      req0_valid = 1'b1; req0_addr = 5'd31; req0_data = 32'h0000_CAFE;
      cycle();
      req0_valid = 1'b0;
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
Owns the single register-file write port (write enable, write address, write data) and shares it between two writeback requesters.
- Requester 0 is the core writeback path.
- Requester 1 is a secondary path (long-latency load return / debug write).
- After reset it sweeps zeros into every register before granting any requester, because the register array itself has no reset.
- Sits between the writeback sources and the register file's write port.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, registers cleared by the init sweep (must equal 2**ADDR_W)
STARVE_LIMIT, 4, consecutive stalled cycles before requester 1 is promoted (used only with the optional feature)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a write pending
req0_addr  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write data
req0_ready  output  1  requester 0 write accepted this cycle
req1_valid  input  1  requester 1 has a write pending
req1_addr  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write data
req1_ready  output  1  requester 1 write accepted this cycle
rf_we  output  1  register-file write enable (registered)
rf_addr  output  ADDR_W  register-file write address (registered)
rf_wdata  output  DATA_W  register-file write data (registered)
init_done  output  1  high once the clear sweep has completed
x0_drop  output  1  one-cycle pulse: an accepted write targeted x0 and was suppressed

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=INIT, init_ptr=0, rf_we=0, rf_addr=0, rf_wdata=0, init_done=0, x0_drop=0, starve_cnt=0.
- req0_ready and req1_ready are 0 while in reset.
- States: INIT and RUN. There is no other state.
- INIT, every cycle:
  - register rf_we=1, rf_addr=init_ptr, rf_wdata=0, then init_ptr+1.
  - The cycle that issues init_ptr==NUM_REGS-1 moves the FSM to RUN and sets init_done=1 at that same edge.
  - Sweep length is exactly NUM_REGS cycles.
  - Both readies are 0 in INIT; requester valids are ignored.
- RUN, readies are combinational from state, valids and starve_cnt:
  - Default (fixed priority): req0_ready=1; req1_ready = !req0_valid.
  - Transfer on a port means valid && ready in the same cycle. At most one transfer per cycle.
- Write-port latency: one cycle.
  - A transfer in cycle N drives rf_we/rf_addr/rf_wdata from the winning request during cycle N+1.
  - The register file commits at the end of N+1.
- x0 handling: a transfer with addr==0 is acknowledged (ready high) but the write is suppressed.
  - Registered rf_we=0 and x0_drop=1 for one cycle.
- No transfer in a cycle: next-cycle rf_we=0; rf_addr and rf_wdata hold their previous values.
- Both requesters targeting the same register in the same cycle: only the granted one is written. No merging; the loser retries.
- Requester rule: once valid is high, addr and data stay stable and valid stays high until ready. The arbiter does not check this.
- Back-to-back transfers are permitted every cycle, giving throughput of 1 write/cycle.
- init_done stays 1 until the next reset.
- Reset mid-sweep or mid-transfer: immediate return to INIT with init_ptr=0.
  - A write accepted but not yet presented on rf_* is dropped.
  - The sweep restarts from register 0.

Optional Feature:
Macro: RF_STARVE_GUARD_EN
- Defined:
  - starve_cnt (width clog2(STARVE_LIMIT+1)) increments each RUN cycle with req1_valid && !req1_ready, saturating at STARVE_LIMIT.
  - It clears on a req1 transfer or when req1_valid is low.
  - While starve_cnt==STARVE_LIMIT: req1_ready=1 and req0_ready=0.
  - Requester 1 is therefore granted no later than STARVE_LIMIT+1 cycles after it raises valid.
- Not defined: strict fixed priority for requester 0, no counter logic, and STARVE_LIMIT has no effect.

Test Plan:
- Reset, then hold both valids high -> rf_we=1 for 32 consecutive cycles with rf_addr 0..31 and rf_wdata=0; init_done rises after the 32nd write is issued; no ready before that.
- RUN, req0 addr=5 data=0xDEADBEEF -> req0_ready=1 the same cycle; next cycle rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF.
- Both valid, req0 addr=3 data=0x11, req1 addr=3 data=0x22, req0 dropping after one grant -> cycle N: req0 granted, rf_wdata=0x11 at N+1; cycle N+1: req1 granted, rf_wdata=0x22 at N+2.
- req1 addr=0 data=0xFFFF_FFFF alone -> req1_ready=1; next cycle rf_we=0 and x0_drop=1 for exactly one cycle.
- RF_STARVE_GUARD_EN defined, STARVE_LIMIT=4, req0 and req1 valid continuously -> req0 granted for 4 cycles, req1 granted in cycle 5, then req0 resumes. Without the macro, req1 is never granted.
- Assert rst at sweep index 10 -> all outputs return to reset values asynchronously; after release the sweep restarts at rf_addr=0 and completes 32 writes.
